// File: rtl/sum_pipe.sv
// sum_pipe: WIDTH-bit adder with per-transaction wrap/saturate and
// unsigned/signed modes. The result passes through a STAGES-deep elastic
// pipeline. Each stage has a valid bit, and empty stages fill without waiting
// for downstream.
module sum_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  // Each stage stores {c, ovf}. Bit 0 holds the overflow flag.
  logic [STAGES:1]           valid_reg;
  logic [STAGES:1][WIDTH:0]  data_reg;
  logic [STAGES:1]           ready;

  logic [WIDTH:0]            sum_full;
  logic [WIDTH-1:0]          sat_val;
  logic [WIDTH-1:0]          c_calc;
  logic                      ovf_calc;

  // Stage i can load if any stage from i up to the output is empty, or if the
  // consumer is taking the head this cycle. This is the unrolled form of
  // ready[i] = !valid[i] || ready[i+1].
  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_ready
      assign ready[gi] = out_ready || !(&valid_reg[STAGES:gi]);
    end
  endgenerate

  assign in_ready  = ready[1];
  assign out_valid = valid_reg[STAGES];
  assign c         = data_reg[STAGES][WIDTH:1];
  assign ovf       = data_reg[STAGES][0];

  // Compute the sum, the overflow flag and the saturated result for the operands
  // currently on the input.
  always_comb begin
    sum_full = {1'b0, a} + {1'b0, b};
    ovf_calc = 1'b0;
    sat_val  = '1;
    if (mode[1]) begin
      ovf_calc = (a[WIDTH-1] == b[WIDTH-1]) && (sum_full[WIDTH-1] != a[WIDTH-1]);
      // Signed overflow only occurs when both signs match. Clamp toward that sign.
      sat_val  = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf_calc = sum_full[WIDTH];
      sat_val  = '1;
    end
    c_calc = (mode[0] && ovf_calc) ? sat_val : sum_full[WIDTH-1:0];
  end

  // Stage registers. Data loads only alongside a valid token, so idle or
  // unknown operands never reach c/ovf, and a held result stays put.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      valid_reg <= '0;
      data_reg  <= '0;
    end else begin
      if (ready[1]) begin
        valid_reg[1] <= in_valid;
        if (in_valid) begin
          data_reg[1] <= {c_calc, ovf_calc};
        end
      end
      for (int i = 2; i <= STAGES; i++) begin
        if (ready[i]) begin
          valid_reg[i] <= valid_reg[i-1];
          if (valid_reg[i-1]) begin
            data_reg[i] <= data_reg[i-1];
          end
        end
      end
    end
  end

endmodule
